// File: rtl/inst_fetch_if.sv
// Loader, decoder and status bundle of the cube processor's instruction fetch unit.
interface inst_fetch_if #(
    parameter int AW = 8
);
    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_addr;
    logic [15:0]   ld_data;
    logic          start;
    logic [AW-1:0] pc_in;
    logic          pc_we;
    logic [15:0]   op;
    logic [AW-1:0] pc;
    logic          running;
    logic          halted;
    logic [15:0]   icount;

    // Loader, start control and decoder branch side
    modport master (
        output ld_valid, ld_addr, ld_data, start, pc_in, pc_we,
        input  ld_ready, op, pc, running, halted, icount
    );

    // Fetch unit side
    modport slave (
        input  ld_valid, ld_addr, ld_data, start, pc_in, pc_we,
        output ld_ready, op, pc, running, halted, icount
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: 2**AW x 16 program memory, loader port, IDLE/RUN/HALT
// sequencer, program counter and saturating retired-instruction counter.
module inst_fetch #(
    parameter int          AW      = 8,
    parameter logic [15:0] HALT_OP = 16'hFFFF,
    parameter logic [15:0] NOP_OP  = 16'hFFFF
) (
    input logic         clk,
    input logic         rst,
    inst_fetch_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    logic [15:0]   mem [2**AW];
    state_t        state, state_nx;
    logic [AW-1:0] pc_q, pc_nx;
    logic [15:0]   icount_q, icount_nx;
    logic [15:0]   fetch_word;
    logic          load_en;

    // Combinational read so the decoder sees mem[pc] in the same cycle
    always_comb begin
        fetch_word = mem[pc_q];
        load_en    = (state == IDLE) && bus.ld_valid;
    end

    // Program memory write port, loader only while idle; contents survive reset
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[bus.ld_addr] <= bus.ld_data;
        end
    end

    // Sequencer, program counter and retired-instruction counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pc_q     <= '0;
            icount_q <= '0;
        end else begin
            state    <= state_nx;
            pc_q     <= pc_nx;
            icount_q <= icount_nx;
        end
    end

    // Next state: a halt fetch beats a taken branch; start is only honoured outside RUN
    always_comb begin
        state_nx  = state;
        pc_nx     = pc_q;
        icount_nx = icount_q;
        case (state)
            IDLE, HALT: begin
                if (bus.start) begin
                    state_nx  = RUN;
                    pc_nx     = '0;
                    icount_nx = '0;
                end
            end
            RUN: begin
                if (fetch_word == HALT_OP) begin
                    state_nx = HALT;
                end else begin
                    pc_nx = bus.pc_we ? bus.pc_in : pc_q + AW'(1);
                    if (icount_q != '1) begin
                        icount_nx = icount_q + 16'd1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output decode from the registered state
    always_comb begin
        bus.op       = (state == RUN) ? fetch_word : NOP_OP;
        bus.ld_ready = (state == IDLE);
        bus.running  = (state == RUN);
        bus.halted   = (state == HALT);
        bus.pc       = pc_q;
        bus.icount   = icount_q;
    end
endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: expected op/pc pairs are queued as each program
// is started and popped as the fetch unit steps through it.
module tb_inst_fetch;
    localparam int AW = 8;

    typedef struct {
        logic [15:0]   op;
        logic [AW-1:0] pc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];

    inst_fetch_if #(.AW(AW)) bus ();

    inst_fetch #(
        .AW(AW),
        .HALT_OP(16'hFFFF),
        .NOP_OP(16'hFFFF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] op, input logic [AW-1:0] pc);
        exp_t e;
        e.op = op;
        e.pc = pc;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL %s: observed empty scoreboard expected entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, " op"}, bus.op, e.op);
            check({tag, " pc"}, {8'h00, bus.pc}, {8'h00, e.pc});
            check({tag, " running"}, {15'd0, bus.running}, 16'd1);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [15:0] d);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = a;
        bus.ld_data  = d;
        @(negedge clk);
        bus.ld_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic check_halt(input string tag, input logic [AW-1:0] pc, input logic [15:0] ic);
        check({tag, " halted"}, {15'd0, bus.halted}, 16'd1);
        check({tag, " running"}, {15'd0, bus.running}, 16'd0);
        check({tag, " pc"}, {8'h00, bus.pc}, {8'h00, pc});
        check({tag, " icount"}, bus.icount, ic);
        check({tag, " op"}, bus.op, 16'hFFFF);
    endtask

    initial begin
        rst          = 1'b1;
        bus.ld_valid = 1'b0;
        bus.ld_addr  = '0;
        bus.ld_data  = '0;
        bus.start    = 1'b0;
        bus.pc_in    = '0;
        bus.pc_we    = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst op", bus.op, 16'hFFFF);
        check("rst pc", {8'h00, bus.pc}, 16'h0000);
        check("rst icount", bus.icount, 16'h0000);
        check("rst running", {15'd0, bus.running}, 16'd0);
        check("rst halted", {15'd0, bus.halted}, 16'd0);
        check("rst ld_ready", {15'd0, bus.ld_ready}, 16'd1);

        // 1: straight-line program
        load(8'd0, 16'h1100);
        load(8'd1, 16'h2200);
        load(8'd2, 16'h3300);
        load(8'd3, 16'hFFFF);
        push(16'h1100, 8'd0);
        push(16'h2200, 8'd1);
        push(16'h3300, 8'd2);
        push(16'hFFFF, 8'd3);
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            pop_check("t1 seq");
            @(negedge clk);
        end
        check_halt("t1 halt", 8'd3, 16'd3);

        // 2: taken branch to a halt word
        do_reset();
        load(8'd0, 16'h0A0A);
        load(8'd1, 16'h0B0B);
        load(8'd5, 16'hFFFF);
        push(16'h0A0A, 8'd0);
        push(16'h0B0B, 8'd1);
        push(16'hFFFF, 8'd5);
        pulse_start();
        pop_check("t2 A");
        @(negedge clk);
        pop_check("t2 B");
        bus.pc_we = 1'b1;
        bus.pc_in = 8'd5;
        @(negedge clk);
        bus.pc_we = 1'b0;
        pop_check("t2 target");
        @(negedge clk);
        check_halt("t2 halt", 8'd5, 16'd2);

        // 3: pc wrap-around
        do_reset();
        for (int i = 0; i < 256; i++) begin
            load(AW'(i), (i == 2) ? 16'hFFFF : 16'(i));
        end
        push(16'h0000, 8'd0);
        push(16'h00FE, 8'd254);
        push(16'h00FF, 8'd255);
        push(16'h0000, 8'd0);
        push(16'h0001, 8'd1);
        push(16'hFFFF, 8'd2);
        pulse_start();
        bus.pc_we = 1'b1;
        bus.pc_in = 8'd254;
        pop_check("t3 wrap");
        @(negedge clk);
        bus.pc_we = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pop_check("t3 wrap");
            @(negedge clk);
        end
        check_halt("t3 halt", 8'd2, 16'd5);

        // 4a: loader is gated off during RUN
        do_reset();
        pulse_start();
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 8'd0;
        bus.ld_data  = 16'hABCD;
        for (int i = 0; i < 3; i++) begin
            check("t4 ld_ready run", {15'd0, bus.ld_ready}, 16'd0);
            @(negedge clk);
        end
        check("t4 ld_ready halt", {15'd0, bus.ld_ready}, 16'd0);
        bus.ld_valid = 1'b0;
        do_reset();
        push(16'h0000, 8'd0);
        pulse_start();
        pop_check("t4 readback");
        // 4b: load and start in the same idle cycle
        do_reset();
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 8'd0;
        bus.ld_data  = 16'h5A5A;
        push(16'h5A5A, 8'd0);
        pulse_start();
        bus.ld_valid = 1'b0;
        pop_check("t4 load+start");

        // 5: asynchronous reset mid-run (program is 5A5A, 0001, FFFF)
        do_reset();
        pulse_start();
        repeat (2) @(negedge clk);
        check("t5 pre pc", {8'h00, bus.pc}, 16'd2);
        #2 rst = 1'b1;
        #1;
        check("t5 async op", bus.op, 16'hFFFF);
        check("t5 async pc", {8'h00, bus.pc}, 16'd0);
        check("t5 async running", {15'd0, bus.running}, 16'd0);
        check("t5 async icount", bus.icount, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        push(16'h5A5A, 8'd0);
        push(16'h0001, 8'd1);
        push(16'hFFFF, 8'd2);
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            pop_check("t5 rerun");
            @(negedge clk);
        end
        check_halt("t5 halt", 8'd2, 16'd2);

        // 6: restart from HALT, then saturate icount in a branch loop
        pulse_start();
        check("t6 restart pc", {8'h00, bus.pc}, 16'd0);
        check("t6 restart icount", bus.icount, 16'd0);
        check("t6 restart running", {15'd0, bus.running}, 16'd1);
        bus.pc_we = 1'b1;
        bus.pc_in = 8'd0;
        repeat (65534) @(negedge clk);
        check("t6 icount FFFE", bus.icount, 16'hFFFE);
        repeat (10) @(negedge clk);
        check("t6 icount sat", bus.icount, 16'hFFFF);
        check("t6 loop pc", {8'h00, bus.pc}, 16'd0);
        bus.pc_we = 1'b0;

        check("scoreboard drained", 16'(sb.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction source for the cube processor; produces the 16-bit `op` word consumed by the decoder.
- Consumes the decoder's `pc_in` and `pc_we` branch outputs.
- Holds a 256x16 instruction memory. The memory is filled through a valid/ready loader port while idle.
- Runs an IDLE/RUN/HALT sequencer that steps the program counter, and tracks executed-instruction count.

Parameters:
- AW, 8, program-counter and memory address width; depth = 2**AW.
- HALT_OP, 16'hFFFF, instruction word that stops execution.
- NOP_OP, 16'hFFFF, word driven on `op` when not in RUN. Its opcode nibble must decode with no register, memory or pc write.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ld_valid  in  1  loader word present.
- ld_ready  out  1  loader may write; high only in IDLE.
- ld_addr  in  AW  loader write address.
- ld_data  in  16  loader write data.
- start  in  1  begin execution at address 0 (single-cycle pulse).
- pc_in  in  AW  branch target from decoder.
- pc_we  in  1  branch taken from decoder.
- op  out  16  current instruction to decoder.
- pc  out  AW  current program counter.
- running  out  1  high in RUN.
- halted  out  1  high in HALT.
- icount  out  16  instructions retired since last start, saturating.

Behaviour:
- One clock; reset is asynchronous and active-high on rst.
- Reset values: state=IDLE, pc=0, icount=0, running=0, halted=0, ld_ready=1, op=NOP_OP. Memory contents are not reset.
- Memory: synchronous write, asynchronous (combinational) read. The decoder and datapath are single-cycle, so `op` = mem[pc] in the same cycle.
- Load: in IDLE, ld_valid&ld_ready writes ld_data to mem[ld_addr] at the clock edge, one word per cycle. ld_ready=0 in RUN and HALT, and ld_valid is ignored there.
- IDLE:
  - op=NOP_OP.
  - start -> RUN with pc<=0 and icount<=0.
  - start and a load in the same cycle: the write is performed and RUN is entered. The word written is visible at its address on the first RUN cycle.
- RUN:
  - op=mem[pc].
  - At each edge, if op==HALT_OP: go to HALT, pc holds, icount unchanged.
  - Otherwise: pc<=pc_we ? pc_in : pc+1, and icount<=icount+1 saturating at 16'hFFFF.
  - pc+1 wraps from 2**AW-1 to 0.
  - A HALT_OP fetch takes priority over pc_we in the same cycle.
  - start is ignored in RUN.
- HALT:
  - op=NOP_OP, halted=1, pc and icount hold their final values for readout.
  - start -> RUN with pc<=0, icount<=0.
  - No path from HALT back to IDLE except rst. Memory reload therefore requires reset.
- running = (state==RUN); halted = (state==HALT). Both are registered state decodes, never high together.
- pc_we asserted in IDLE or HALT is ignored.
- rst asserted mid-RUN: immediate return to IDLE, pc=0, icount=0, op=NOP_OP. Memory retains its program, so start reruns it without reloading.

Test Plan:
1. Load & straight-line:
   - Stimulus: reset; load mem[0..3] = 16'h1100, 16'h2200, 16'h3300, HALT_OP; pulse start.
   - Required: op sequence 1100, 2200, 3300, FFFF on consecutive cycles; HALT on the next edge with pc=3, icount=3, halted=1, op=NOP_OP.
2. Branch:
   - Stimulus: program mem[0]=A, mem[1]=B, mem[5]=HALT_OP; drive pc_we=1, pc_in=5 during the cycle op=B.
   - Required: next op=FFFF at pc=5; icount=2 in HALT.
3. Wrap-around:
   - Stimulus: fill mem[0..255] with non-halt words except mem[2]=HALT_OP; pulse start with pc_we=1, pc_in=254 on the first cycle.
   - Required: pc sequence 0, 254, 255, 0, 1, 2 then HALT; icount=5.
4. Loader gating:
   - Stimulus: assert ld_valid with ld_addr=0, ld_data=16'hABCD during RUN.
   - Required: ld_ready=0 throughout; mem[0] unchanged after reset + readback via rerun.
   - Stimulus: load and start in the same IDLE cycle to address 0.
   - Required: first RUN op equals the new word.
5. Reset mid-run:
   - Stimulus: assert rst asynchronously between edges while pc=2 in RUN.
   - Required: op=NOP_OP, pc=0, running=0 before the next clock edge; start reruns the program from word 0.
6. Restart from HALT & saturation:
   - Stimulus: start in HALT.
   - Required: pc=0, icount=0, running=1.
   - Stimulus: an infinite loop via pc_we for >65535 cycles.
   - Required: icount holds at 16'hFFFF.
